tc_bus_arbiter: RTL

Two-master arbiter and access sequencer for the timer/counter register port (CTRL at 2'b00, PRESET at 2'b01, COUNT at 2'b10).
- Master 0 is the CPU bridge; master 1 is a secondary agent (debug/DMA).
- Serialises register reads and writes from both masters onto the single timer port.
- Uses round-robin fairness and can write-protect CTRL against master 1.
- Sits between the system bus decode and the timer instance.

---
 rtl/tc_bus_arbiter.sv | 161 ++++++++++++++++
 1 files changed

// File: rtl/tc_bus_arbiter.sv
// Two-master arbiter and access sequencer for the timer/counter register port.
// Master 0 is the CPU bridge and master 1 is a secondary agent (debug/DMA).
// Accesses are serialised round-robin onto the timer port. Each access takes
// IDLE (grant) -> ACCESS (timer strobe) -> DONE (completion pulse).
// All outputs come directly from flops.
//
// state  | meaning
// -------+------------------------------------------------------------
// IDLE   | waiting for a request; a grant latches address, data and we
// ACCESS | timer strobe cycle; read data is captured at the closing edge
// DONE   | completion pulse to the granted master, with err if blocked
module tc_bus_arbiter #(
    parameter bit M1_CTRL_WR_EN = 1'b0,
    parameter bit RST_LAST      = 1'b1
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        m0_req,
    input  logic        m0_we,
    input  logic [1:0]  m0_addr,
    input  logic [31:0] m0_wdata,
    output logic        m0_done,
    output logic [31:0] m0_rdata,
    output logic        m0_err,
    input  logic        m1_req,
    input  logic        m1_we,
    input  logic [1:0]  m1_addr,
    input  logic [31:0] m1_wdata,
    output logic        m1_done,
    output logic [31:0] m1_rdata,
    output logic        m1_err,
    output logic        tc_we,
    output logic [1:0]  tc_addr,
    output logic [31:0] tc_wdata,
    input  logic [31:0] tc_rdata,
    output logic        busy,
    output logic        gnt_id
);

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        ACCESS = 2'd1,
        DONE   = 2'd2
    } state_t;

    state_t      state_q;
    logic        last_q;
    logic        gnt_q;
    logic        we_q;
    logic        blk_q;
    logic        busy_q;
    logic        tc_we_q;
    logic [1:0]  tc_addr_q;
    logic [31:0] tc_wdata_q;
    logic        m0_done_q;
    logic [31:0] m0_rdata_q;
    logic        m1_done_q;
    logic [31:0] m1_rdata_q;
    logic        m1_err_q;

    logic        gnt_d;
    logic        sel_we_d;
    logic [1:0]  sel_addr_d;
    logic [31:0] sel_wdata_d;
    logic        blk_d;

    // Grant decision and selected master's fields; only used in IDLE.
    always_comb begin
        gnt_d = m1_req;
        if (m0_req && m1_req) begin
            gnt_d = ~last_q;
        end
        sel_we_d    = gnt_d ? m1_we    : m0_we;
        sel_addr_d  = gnt_d ? m1_addr  : m0_addr;
        sel_wdata_d = gnt_d ? m1_wdata : m0_wdata;
        blk_d       = gnt_d && m1_we && (m1_addr == 2'b00) && (M1_CTRL_WR_EN == 1'b0);
    end

    // Sequencer FSM; reset aborts any access in flight, dropping tc_we at once.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q    <= IDLE;
            last_q     <= RST_LAST;
            gnt_q      <= 1'b0;
            we_q       <= 1'b0;
            blk_q      <= 1'b0;
            busy_q     <= 1'b0;
            tc_we_q    <= 1'b0;
            tc_addr_q  <= 2'b00;
            tc_wdata_q <= 32'h0;
            m0_done_q  <= 1'b0;
            m0_rdata_q <= 32'h0;
            m1_done_q  <= 1'b0;
            m1_rdata_q <= 32'h0;
            m1_err_q   <= 1'b0;
        end else begin
            case (state_q)
                IDLE: begin
                    if (m0_req || m1_req) begin
                        gnt_q      <= gnt_d;
                        last_q     <= gnt_d;
                        tc_addr_q  <= sel_addr_d;
                        tc_wdata_q <= sel_wdata_d;
                        tc_we_q    <= sel_we_d && !blk_d;
                        we_q       <= sel_we_d;
                        blk_q      <= blk_d;
                        busy_q     <= 1'b1;
                        state_q    <= ACCESS;
                    end
                end
                ACCESS: begin
                    tc_we_q <= 1'b0;
                    // Writes (including blocked ones) leave rdata untouched.
                    if (!we_q) begin
                        if (gnt_q) begin
                            m1_rdata_q <= tc_rdata;
                        end else begin
                            m0_rdata_q <= tc_rdata;
                        end
                    end
                    if (gnt_q) begin
                        m1_done_q <= 1'b1;
                        m1_err_q  <= blk_q;
                    end else begin
                        m0_done_q <= 1'b1;
                    end
                    state_q <= DONE;
                end
                DONE: begin
                    m0_done_q <= 1'b0;
                    m1_done_q <= 1'b0;
                    m1_err_q  <= 1'b0;
                    busy_q    <= 1'b0;
                    state_q   <= IDLE;
                end
                default: begin
                    tc_we_q   <= 1'b0;
                    m0_done_q <= 1'b0;
                    m1_done_q <= 1'b0;
                    m1_err_q  <= 1'b0;
                    busy_q    <= 1'b0;
                    state_q   <= IDLE;
                end
            endcase
        end
    end

    // Master 0 can never be blocked, so its error flag is tied off.
    assign m0_err   = 1'b0;
    assign m0_done  = m0_done_q;
    assign m0_rdata = m0_rdata_q;
    assign m1_done  = m1_done_q;
    assign m1_rdata = m1_rdata_q;
    assign m1_err   = m1_err_q;
    assign tc_we    = tc_we_q;
    assign tc_addr  = tc_addr_q;
    assign tc_wdata = tc_wdata_q;
    assign busy     = busy_q;
    assign gnt_id   = gnt_q;

endmodule
